// File: rtl/reg_file_mp_clr.sv
// Multi-read-port register file with a sequenced clear engine (one entry per cycle).
// Define REG_FILE_BYPASS_EN to forward same-cycle IDLE writes to matching read ports.
module reg_file_mp_clr #(
    parameter int unsigned      pBITS     = 8,
    parameter int unsigned      pWIDHT    = 2,
    parameter int unsigned      pRD_PORTS = 2,
    parameter logic [pBITS-1:0] pCLR_VAL  = '0
) (
    input  logic                          iclk,
    input  logic                          irst_n,
    input  logic                          iwr_en,
    input  logic [pWIDHT-1:0]             iw_addr,
    input  logic [pBITS-1:0]              iw_data,
    input  logic [pRD_PORTS*pWIDHT-1:0]   ir_addr,
    output logic [pRD_PORTS*pBITS-1:0]    or_data,
    input  logic                          iclr_start,
    output logic                          oclr_busy,
    output logic                          oclr_done,
    output logic                          owr_drop
);

    localparam int unsigned     DEPTH    = 2**pWIDHT;
    localparam logic [pWIDHT:0] LAST_IDX = {1'b0, {pWIDHT{1'b1}}};

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state_q, state_d;
    logic [pWIDHT:0]   cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              drop_q, drop_d;
    logic [pBITS-1:0]  mem_q [DEPTH];

    logic              we;
    logic [pWIDHT-1:0] waddr;
    logic [pBITS-1:0]  wdata;
    logic [pWIDHT-1:0] rd_addr;
    logic [pBITS-1:0]  rd_data;

    // Single array write port shared by user writes (IDLE) and the clear sweep (CLEAR).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        drop_d  = 1'b0;
        we      = 1'b0;
        waddr   = iw_addr;
        wdata   = iw_data;
        case (state_q)
            IDLE: begin
                we = iwr_en;
                if (iclr_start) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                we     = 1'b1;
                waddr  = cnt_q[pWIDHT-1:0];
                wdata  = pCLR_VAL;
                cnt_d  = cnt_q + 1'b1;
                drop_d = iwr_en;
                if (cnt_q == LAST_IDX) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
        end
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= pCLR_VAL;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb begin
        or_data = '0;
        rd_addr = '0;
        rd_data = '0;
        for (int unsigned k = 0; k < pRD_PORTS; k++) begin
            rd_addr = ir_addr[k*pWIDHT +: pWIDHT];
            rd_data = mem_q[rd_addr];
`ifdef REG_FILE_BYPASS_EN
            if ((state_q == IDLE) && iwr_en && (rd_addr == iw_addr)) begin
                rd_data = iw_data;
            end
`endif
            or_data[k*pBITS +: pBITS] = rd_data;
        end
    end

    assign oclr_busy = (state_q == CLEAR);
    assign oclr_done = done_q;
    assign owr_drop  = drop_q;

endmodule
